hazard_stall_ctrl: RTL

Pipeline sequencing controller for the 5-stage RV32 core.
- Drives the enable and flush inputs of PC, IF/ID, ID/EX and EX/MEM pipeline registers.
- Resolves load-use hazards, taken-branch/jump redirects and multi-cycle data-memory waits.
- Sits beside ID; reads register indices, opcodes and RegWrite from IF/ID and ID/EX, plus status from EX and MEM.

---
 rtl/rv_pipe_pkg.sv | 29 ++
 rtl/hazard_stall_ctrl_if.sv | 35 +++
 rtl/hazard_stall_ctrl_hazard_detect.sv | 23 ++
 rtl/hazard_stall_ctrl.sv | 117 +++++++++++
 4 files changed

// File: rtl/rv_pipe_pkg.sv
// Shared RV32 pipeline definitions: opcode field values (inst[6:2]), stall FSM
// encoding and the rs1/rs2 usage decode shared by hazard and forwarding logic.
package rv_pipe_pkg;

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_OPIMM  = 5'b00100;
  localparam logic [4:0] OPC_OP     = 5'b01100;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_MEM_WAIT = 2'd2
  } stall_state_e;

  // Returns {rs2_used, rs1_used}
  function automatic logic [1:0] rs_used(input logic [4:0] opc);
    logic [1:0] u;
    u[0] = !((opc == OPC_LUI) || (opc == OPC_AUIPC) || (opc == OPC_JAL));
    u[1] = (opc == OPC_OP) || (opc == OPC_STORE) || (opc == OPC_BRANCH);
    return u;
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Hazard controller bundle: IF/ID, ID/EX, EX and MEM status in, pipeline
// register enables/flushes and debug status out.
interface hazard_stall_ctrl_if;
  logic [4:0] ifid_rs1;
  logic [4:0] ifid_rs2;
  logic [4:0] ifid_opcode;
  logic [4:0] idex_rd;
  logic       idex_regwrite;
  logic [4:0] idex_opcode;
  logic       ex_redirect;
  logic       exmem_memop;
  logic       dmem_ready;
  logic       pc_en;
  logic       ifid_en;
  logic       ifid_flush;
  logic       idex_en;
  logic       idex_flush;
  logic       exmem_en;
  logic [1:0] stall_state;
  logic       mem_timeout_err;

  modport master (
    output ifid_rs1, ifid_rs2, ifid_opcode, idex_rd, idex_regwrite, idex_opcode,
           ex_redirect, exmem_memop, dmem_ready,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
           stall_state, mem_timeout_err
  );

  modport slave (
    input  ifid_rs1, ifid_rs2, ifid_opcode, idex_rd, idex_regwrite, idex_opcode,
           ex_redirect, exmem_memop, dmem_ready,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
           stall_state, mem_timeout_err
  );
endinterface

// File: rtl/hazard_stall_ctrl_hazard_detect.sv
// Combinational load-use detector: IF/ID source registers against a load's rd
// in ID/EX. x0 and non-writing instructions never produce a hazard.
module hazard_detect
  import rv_pipe_pkg::*;
(
  input  logic [4:0] i_rs1,
  input  logic [4:0] i_rs2,
  input  logic [4:0] i_opcode,
  input  logic [4:0] i_rd,
  input  logic       i_regwrite,
  input  logic [4:0] i_rd_opcode,
  output logic       o_load_use
);
  logic [1:0] w_used;
  logic       w_hit1;
  logic       w_hit2;

  assign w_used     = rs_used(i_opcode);
  assign w_hit1     = w_used[0] && (i_rd == i_rs1);
  assign w_hit2     = w_used[1] && (i_rd == i_rs2);
  assign o_load_use = (i_rd_opcode == OPC_LOAD) && i_regwrite && (i_rd != 5'd0)
                      && (w_hit1 || w_hit2);
endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: load-use bubbles, EX redirect flushes and
// dmem wait freeze with timeout. HAZARD_PERF_CNT_EN adds event counters.
module hazard_stall_ctrl
  import rv_pipe_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int MEM_TIMEOUT       = 255,
  parameter int CNT_W             = 8
) (
  input  logic                clk,
  input  logic                rst,
  hazard_stall_ctrl_if.slave  bus
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]         perf_lu_stalls,
  output logic [31:0]         perf_flushes,
  output logic [31:0]         perf_mem_waits
`endif
);
  stall_state_e     r_state, w_state_nxt;
  logic [CNT_W-1:0] r_lu_cnt, w_lu_nxt;
  logic [CNT_W-1:0] r_wait_cnt, w_wait_nxt;
  logic             r_err;
  logic             w_load_use, w_timeout, w_mem_wait;
  logic             w_lu_stall;

  hazard_detect u_hd (
    .i_rs1       (bus.ifid_rs1),
    .i_rs2       (bus.ifid_rs2),
    .i_opcode    (bus.ifid_opcode),
    .i_rd        (bus.idex_rd),
    .i_regwrite  (bus.idex_regwrite),
    .i_rd_opcode (bus.idex_opcode),
    .o_load_use  (w_load_use)
  );

  // On timeout the freeze is dropped for this cycle so the stuck access drains.
  assign w_timeout  = (r_state == ST_MEM_WAIT) && (r_wait_cnt >= CNT_W'(MEM_TIMEOUT));
  assign w_mem_wait = bus.exmem_memop && !bus.dmem_ready && !w_timeout;
  assign w_lu_stall = !w_mem_wait && !bus.ex_redirect
                      && ((r_state == ST_LU_STALL) || w_load_use);

  always_comb begin
    w_state_nxt    = ST_RUN;
    w_lu_nxt       = '0;
    w_wait_nxt     = '0;
    bus.pc_en      = 1'b1;
    bus.ifid_en    = 1'b1;
    bus.ifid_flush = 1'b0;
    bus.idex_en    = 1'b1;
    bus.idex_flush = 1'b0;
    bus.exmem_en   = 1'b1;
    if (w_mem_wait) begin
      bus.pc_en    = 1'b0;
      bus.ifid_en  = 1'b0;
      bus.idex_en  = 1'b0;
      bus.exmem_en = 1'b0;
      w_state_nxt  = ST_MEM_WAIT;
      w_wait_nxt   = (r_wait_cnt == '1) ? r_wait_cnt : r_wait_cnt + CNT_W'(1);
    end else if (bus.ex_redirect) begin
      bus.ifid_flush = 1'b1;
      bus.idex_flush = 1'b1;
    end else if (w_lu_stall) begin
      bus.pc_en      = 1'b0;
      bus.ifid_en    = 1'b0;
      bus.idex_flush = 1'b1;
      if (r_state == ST_LU_STALL) begin
        if (r_lu_cnt != CNT_W'(LOAD_STALL_CYCLES - 1)) begin
          w_state_nxt = ST_LU_STALL;
          w_lu_nxt    = r_lu_cnt + CNT_W'(1);
        end
      end else if (LOAD_STALL_CYCLES > 1) begin
        w_state_nxt = ST_LU_STALL;
        w_lu_nxt    = CNT_W'(1);
      end
    end
    if (!rst) begin
      bus.pc_en      = 1'b0;
      bus.ifid_en    = 1'b0;
      bus.ifid_flush = 1'b1;
      bus.idex_en    = 1'b0;
      bus.idex_flush = 1'b1;
      bus.exmem_en   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_RUN;
      r_lu_cnt   <= '0;
      r_wait_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_lu_cnt   <= w_lu_nxt;
      r_wait_cnt <= w_wait_nxt;
      if (w_timeout) r_err <= 1'b1;
    end
  end

  assign bus.stall_state     = r_state;
  assign bus.mem_timeout_err = r_err;

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_lu_stalls <= '0;
      perf_flushes   <= '0;
      perf_mem_waits <= '0;
    end else begin
      if (w_lu_stall)                     perf_lu_stalls <= perf_lu_stalls + 32'd1;
      if (!w_mem_wait && bus.ex_redirect) perf_flushes   <= perf_flushes + 32'd1;
      if (w_mem_wait)                     perf_mem_waits <= perf_mem_waits + 32'd1;
    end
  end
`endif
endmodule
